// File: rtl/cpu_bus_initiator.sv
// ---------------------------------------------------------------------------
// cpu_bus_initiator
//
// Initiator end of the CPU's byte-wide memory bus. Takes 8/16-bit read/write
// requests from the core and turns them into single-byte bus cycles against
// the SoC memory responder. 16-bit transfers are little-endian: the low byte
// goes to addr and the high byte to addr+1. The address wraps at 16 bits.
//
// Handshakes:
//   req:  a request transfers on the rising edge where req_valid && req_ready.
//         req_ready is high only in IDLE. req_* are ignored at all other times.
//   rsp:  rsp_valid is a one-cycle pulse. rsp_rdata and rsp_err are valid in
//         the same cycle. There is no backpressure.
//   bus:  a byte completes on the edge where (bus_read|bus_write) && !bus_wait.
//         Every strobe is followed by at least one low cycle.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   request handshake
//   req_write         1 = write, 0 = read
//   req_wide          1 = 16-bit, 0 = 8-bit
//   req_addr          byte address (low byte address for wide)
//   req_wdata         write data; only [7:0] is used for 8-bit transfers
//   rsp_valid         transfer finished (one-cycle pulse)
//   rsp_rdata         read data; 8-bit reads are zero-extended; 0 for writes
//   rsp_err           1 = a byte cycle timed out
//   bus_address_out   byte address of the current bus cycle
//   bus_data_out      write byte of the current bus cycle
//   bus_data_in       read byte from the responder
//   bus_read          read strobe
//   bus_write         write strobe
//   bus_wait          responder not done yet
//   dbg_state         current FSM state, for debug and checkers
//
// Parameter:
//   TIMEOUT_CYCLES    maximum number of wait edges per byte. 0 = no timeout.
// ---------------------------------------------------------------------------
module cpu_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_wide,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] bus_address_out,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        bus_read,
    output logic        bus_write,
    input  logic        bus_wait,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BYTE0 = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_BYTE1 = 2'd3;

    // The counter is always at least one bit wide, so it stays legal when the
    // timeout is disabled.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [1:0]       state;
    logic             wr_q;       // latched transfer direction
    logic             wide_q;     // latched transfer size
    logic [7:0]       wdata_hi;   // high write byte, used in BYTE1
    logic [7:0]       rdata_lo;   // low read byte, kept for a wide read
    logic             byte_idx;   // 0 = working on byte0, 1 = working on byte1
    logic             err_q;      // the current transfer timed out
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // The edge being evaluated is the Nth wait edge of the byte, where N is
    // TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt == CNT_LAST);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= 16'h0000;
            rsp_err         <= 1'b0;
            bus_address_out <= 16'h0000;
            bus_data_out    <= 8'h00;
            bus_read        <= 1'b0;
            bus_write       <= 1'b0;
            wr_q            <= 1'b0;
            wide_q          <= 1'b0;
            wdata_hi        <= 8'h00;
            rdata_lo        <= 8'h00;
            byte_idx        <= 1'b0;
            err_q           <= 1'b0;
            wait_cnt        <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q            <= req_write;
                        wide_q          <= req_wide;
                        wdata_hi        <= req_wdata[15:8];
                        rdata_lo        <= 8'h00;
                        byte_idx        <= 1'b0;
                        err_q           <= 1'b0;
                        wait_cnt        <= '0;
                        bus_address_out <= req_addr;
                        bus_data_out    <= req_wdata[7:0];
                        bus_read        <= !req_write;
                        bus_write       <= req_write;
                        req_ready       <= 1'b0;
                        state           <= ST_BYTE0;
                    end
                end

                ST_BYTE0, ST_BYTE1: begin
                    if (!bus_wait) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        state     <= ST_GAP;
                        if (!byte_idx) begin
                            rdata_lo <= wr_q ? 8'h00 : bus_data_in;
                        end
                        // The response is registered here, so it is
                        // presented during the GAP cycle that follows the
                        // final byte.
                        if (byte_idx || !wide_q) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            if (wr_q) begin
                                rsp_rdata <= 16'h0000;
                            end else if (byte_idx) begin
                                rsp_rdata <= {bus_data_in, rdata_lo};
                            end else begin
                                rsp_rdata <= {8'h00, bus_data_in};
                            end
                        end
                    end else if (timeout_hit) begin
                        // Abandon the transfer. GAP sees err_q and skips any
                        // remaining byte.
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        err_q     <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 16'h0000;
                        state     <= ST_GAP;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    // The strobes are low for exactly this cycle. The
                    // responder clears its completion during this turnaround.
                    if (wide_q && !byte_idx && !err_q) begin
                        byte_idx        <= 1'b1;
                        wait_cnt        <= '0;
                        bus_address_out <= bus_address_out + 16'd1;
                        bus_data_out    <= wdata_hi;
                        bus_read        <= !wr_q;
                        bus_write       <= wr_q;
                        state           <= ST_BYTE1;
                    end else begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    bus_read  <= 1'b0;
                    bus_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
